// File: rtl/pp_serial_accumulator7x7.sv
// -----------------------------------------------------------------------------
// pp_serial_accumulator7x7
//
// Consumer end of the 7x7 unsigned radix-4 partial-product interface. One
// valid/ready beat delivers the four sign-extension-encoded rows. The block
// registers them and adds one row per clock into a 16-bit accumulator. The low
// 14 bits of that accumulator are the unsigned product.
//
// Sum computed (mod 2^ACC_W, all rows zero-extended):
//   acc = pp00 + pp01 + (pp02 << 2) + (pp03 << 4)
// The constant-1 sign-extension bits in the encoded rows add up to 2^16.
// They therefore vanish when the accumulator wraps.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      row set valid
//   in_ready   out  1      a row set can be accepted this cycle
//   pp00       in   12     row 0, weight 2^0
//   pp01       in   13     row 1, weight 2^0 (LSB carries the row-0 negate bit)
//   pp02       in   13     row 2, weight 2^2
//   pp03       in   12     row 3, weight 2^4
//   out_valid  out  1      product valid, held until accepted
//   out_ready  in   1      downstream accepts the product
//   product    out  OUT_W  accumulated product
//   busy       out  1      high while rows are being summed
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. After asserting valid, a producer keeps its data stable until
// that edge. Input side: in_ready is high in IDLE, and high in DONE when
// out_ready is high. It therefore depends combinationally on out_ready, so
// the retiring product and the next row set can cross on the same edge.
// Output side: out_valid and product stay stable from the edge that enters
// DONE until the edge where out_ready is sampled high.
// -----------------------------------------------------------------------------
module pp_serial_accumulator7x7 #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      pp00,
    input  logic [12:0]      pp01,
    input  logic [12:0]      pp02,
    input  logic [11:0]      pp03,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] addend;
    logic [1:0]       cnt;
    logic [1:0]       cnt_d;
    logic [12:0]      row1;
    logic [12:0]      row1_d;
    logic [12:0]      row2;
    logic [12:0]      row2_d;
    logic [11:0]      row3;
    logic [11:0]      row3_d;
    logic             out_valid_q;
    logic             accept;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Row pp00 is loaded directly into acc on the accepting edge. The rows
    // left to add are selected by cnt, each at its own weight.
    always_comb begin
        addend = '0;
        case (cnt)
            2'd1:    addend = ACC_W'(row1);
            2'd2:    addend = ACC_W'(row2) << 2;
            2'd3:    addend = ACC_W'(row3) << 4;
            default: addend = '0;
        endcase
    end

    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        row1_d  = row1;
        row2_d  = row2;
        row3_d  = row3;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = ACC;
                    acc_d   = ACC_W'(pp00);
                    cnt_d   = 2'd1;
                    row1_d  = pp01;
                    row2_d  = pp02;
                    row3_d  = pp03;
                end
            end
            ACC: begin
                acc_d = acc + addend;
                cnt_d = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The product retires on this edge. If a new row set is
                // waiting, it is accepted on the same edge, which avoids a
                // bubble.
                if (accept) begin
                    state_d = ACC;
                    acc_d   = ACC_W'(pp00);
                    cnt_d   = 2'd1;
                    row1_d  = pp01;
                    row2_d  = pp02;
                    row3_d  = pp03;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= 2'd0;
            row1        <= '0;
            row2        <= '0;
            row3        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_d;
            acc         <= acc_d;
            cnt         <= cnt_d;
            row1        <= row1_d;
            row2        <= row2_d;
            row3        <= row3_d;
            out_valid_q <= (state_d == DONE);
        end
    end

    assign out_valid = out_valid_q;
    assign product   = acc[OUT_W-1:0];
    assign busy      = (state == ACC);

endmodule

// File: tb/tb_pp_serial_accumulator7x7.sv
// -----------------------------------------------------------------------------
// tb_pp_serial_accumulator7x7
//
// Bench for pp_serial_accumulator7x7.
// - A table of raw row sets, each with its expected product, applied
//   back-to-back.
// - Hand-written sequences for reset during accumulation, latency and
//   backpressure.
// - A sweep of all 7x7 unsigned operand pairs. Each pair is encoded into
//   radix-4 rows by a local encoder and checked against a*b.
// Expected products are pushed into exp_q when a row set is accepted. They
// are popped when the DUT hands a product to the downstream side.
// -----------------------------------------------------------------------------
module tb_pp_serial_accumulator7x7;

    localparam int OUT_W = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      pp00;
    logic [12:0]      pp01;
    logic [12:0]      pp02;
    logic [11:0]      pp03;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] product;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] mon_exp;

    typedef struct {
        logic [11:0]      p0;
        logic [12:0]      p1;
        logic [12:0]      p2;
        logic [11:0]      p3;
        logic [OUT_W-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    pp_serial_accumulator7x7 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp00      (pp00),
        .pp01      (pp01),
        .pp02      (pp02),
        .pp03      (pp03),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_checks=%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: a product retires on each posedge where out_valid and
    // out_ready are both high. Both are sampled on the preceding negedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_product", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("product", 32'(product), 32'(mon_exp));
            end
        end
    end

    // ---------------- encoder for the operand sweep ----------------
    // Radix-4 digits of the zero-extended multiplier b. Each row holds x = m
    // or ~m (9 bits, m = |digit|*a) plus a negate bit one row up. The
    // sign-extension constants sum to 2^16.
    function automatic void encode(input int a, input int b,
                                   output logic [11:0] p0, output logic [12:0] p1,
                                   output logic [12:0] p2, output logic [11:0] p3);
        logic [8:0] bx;
        logic [8:0] m;
        logic [8:0] x[4];
        logic       n[4];
        int         d;
        bx = {8'(b), 1'b0};
        for (int i = 0; i < 4; i++) begin
            d    = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
            m    = 9'((d < 0 ? -d : d) * a);
            n[i] = (d < 0);
            x[i] = n[i] ? ~m : m;
        end
        p0 = {~x[0][8], x[0][8], x[0][8], x[0]};
        p1 = {1'b1, ~x[1][8], x[1], 1'b0, n[0]};
        p2 = {1'b1, ~x[2][8], x[2], 1'b0, n[1]};
        p3 = {~x[3][8], x[3], 1'b0, n[2]};
    endfunction

    // ---------------- driver tasks ----------------
    // Entered just after a posedge. Holds the row set until it is accepted.
    // Returns just after the accepting edge.
    task automatic send(input logic [11:0] p0, input logic [12:0] p1,
                        input logic [12:0] p2, input logic [11:0] p3,
                        input logic [OUT_W-1:0] exp, input bit keep_valid,
                        output int acc_cyc);
        int g;
        g        = 0;
        pp00     = p0;
        pp01     = p1;
        pp02     = p2;
        pp03     = p3;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("accept_in_time", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back(exp);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c;
        int prev_c;
        int g;
        logic [11:0] e0;
        logic [12:0] e1;
        logic [12:0] e2;
        logic [11:0] e3;

        vecs[0] = '{12'h800, 13'h1800, 13'h1800, 12'h800, 14'd0};
        vecs[1] = '{12'h001, 13'h0002, 13'h0001, 12'h001, 14'd23};
        vecs[2] = '{12'hFFF, 13'h1FFF, 13'h1FFF, 12'hFFF, 14'h2FEA};
        vecs[3] = '{12'h0FF, 13'h0000, 13'h0000, 12'h000, 14'h00FF};
        vecs[4] = '{12'h000, 13'h1000, 13'h0000, 12'h000, 14'h1000};
        vecs[5] = '{12'h000, 13'h0000, 13'h0800, 12'h000, 14'h2000};
        vecs[6] = '{12'h000, 13'h0000, 13'h0000, 12'h100, 14'h1000};
        vecs[7] = '{12'h000, 13'h0000, 13'h0000, 12'h400, 14'h0000};
        vecs[8] = '{12'h000, 13'h0000, 13'h1000, 12'h000, 14'h0000};
        vecs[9] = '{12'h123, 13'h0456, 13'h0089, 12'h012, 14'h08BD};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pp00      = '0;
        pp01      = '0;
        pp02      = '0;
        pp03      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset one cycle after accept: the in-flight product is dropped.
        out_ready = 1'b1;
        pp00 = vecs[1].p0; pp01 = vecs[1].p1; pp02 = vecs[1].p2; pp03 = vecs[1].p3;
        in_valid = 1'b1;
        @(negedge clk);
        check("t1_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t1_busy_after_accept", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t1_rst_out_valid", 32'(out_valid), 32'd0);
        check("t1_rst_busy", 32'(busy), 32'd0);
        check("t1_rst_product", 32'(product), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t1_in_ready_after", 32'(in_ready), 32'd1);
        check("t1_out_valid_after", 32'(out_valid), 32'd0);
        repeat (8) @(posedge clk);
        #1;

        // Latency: out_valid rises on the third edge after the accept.
        send(vecs[0].p0, vecs[0].p1, vecs[0].p2, vecs[0].p3, vecs[0].exp, 1'b0, c);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t2_latency_out_valid", 32'(out_valid), 32'(k == 4));
        end
        drain();

        // Table, back-to-back with out_ready held high.
        out_ready = 1'b1;
        prev_c = 0;
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].exp, (i != 9), c);
            if (i > 0) check("t5_b2b_spacing", 32'(c - prev_c), 32'd4);
            prev_c = c;
        end
        drain();

        // Backpressure in DONE: output stable, input blocked, pp* ignored.
        out_ready = 1'b0;
        send(vecs[1].p0, vecs[1].p1, vecs[1].p2, vecs[1].p3, vecs[1].exp, 1'b0, c);
        g = 0;
        while (!out_valid && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("t6_out_valid_rise", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            e0 = 12'($urandom_range(0, 4095));
            e1 = 13'($urandom_range(0, 8191));
            e2 = 13'($urandom_range(0, 8191));
            e3 = 12'($urandom_range(0, 4095));
            pp00 = e0; pp01 = e1; pp02 = e2; pp03 = e3;
            in_valid = 1'b1;
            @(negedge clk);
            check("t6_hold_out_valid", 32'(out_valid), 32'd1);
            check("t6_hold_product", 32'(product), 32'd23);
            check("t6_hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Every 7x7 unsigned operand pair, back-to-back.
        prev_c = 0;
        for (int a = 0; a < 128; a++) begin
            for (int b = 0; b < 128; b++) begin
                encode(a, b, e0, e1, e2, e3);
                send(e0, e1, e2, e3, 14'(a * b), !(a == 127 && b == 127), c);
                if (a != 0 || b != 0) check("t7_b2b_spacing", 32'(c - prev_c), 32'd4);
                prev_c = c;
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
